// File: rtl/scr_pkg.sv
// Definitions shared by the scrambler index generator and the descrambler:
// mode encodings, the mode-to-block-length mapping and the FSM state type.
package scr_pkg;

    localparam logic [1:0] MODE_N4  = 2'b00;
    localparam logic [1:0] MODE_N6  = 2'b01;
    localparam logic [1:0] MODE_N8  = 2'b10;
    localparam logic [1:0] MODE_N8B = 2'b11;

    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } scr_state_e;

    function automatic logic [3:0] mode_to_n(input logic [1:0] m);
        case (m)
            MODE_N4: return 4'd4;
            MODE_N6: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/scr_buf.sv
// Eight-entry symbol register file: synchronous write, combinational read.
// Contents are not reset; occupancy tracking in the parent decides validity.
module scr_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [8];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/descrambler.sv
// Block descrambler: collects N symbols tagged with their original position,
// then streams them out in position order.
module descrambler #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_index,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              block_done,
    output logic              err_dup,
    output logic              err_range
);
    import scr_pkg::*;

    scr_state_e        state, state_nxt;
    logic [MAX_N-1:0]  occ;
    logic [MAX_N-1:0]  occ_nxt;
    logic [2:0]        rd_ptr;
    logic [3:0]        n_reg;
    logic [3:0]        n_cur;
    logic [3:0]        n_last;
    logic [DATA_W-1:0] rd_data;
    logic              in_fire, out_fire, in_range, dup, wr, full, last_rd;

    assign in_ready  = (state != ST_DRAIN);
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? rd_data : '0;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // In IDLE the block length being latched this cycle is the one that applies.
    assign n_cur    = (state == ST_IDLE) ? mode_to_n(mode) : n_reg;
    assign in_range = ({1'b0, in_index} < n_cur);
    assign dup      = occ[in_index];
    assign wr       = in_fire && in_range && !dup;
    assign n_last   = n_reg - 4'd1;
    assign last_rd  = ({1'b0, rd_ptr} == n_last);

    always_comb begin
        occ_nxt = occ;
        if (wr)
            occ_nxt[in_index] = 1'b1;
        full = 1'b1;
        for (int i = 0; i < MAX_N; i++) begin
            if (4'(i) < n_cur && !occ_nxt[i])
                full = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (wr)                 state_nxt = ST_FILL;
            ST_FILL:  if (wr && full)         state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_fire && last_rd) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= '0;
            rd_ptr     <= '0;
            n_reg      <= 4'd4;
            block_done <= 1'b0;
            err_dup    <= 1'b0;
            err_range  <= 1'b0;
        end else begin
            block_done <= 1'b0;
            err_dup    <= in_fire && in_range && dup;
            err_range  <= in_fire && !in_range;
            if (state == ST_IDLE && in_fire)
                n_reg <= n_cur;
            occ <= occ_nxt;
            if (out_fire) begin
                if (last_rd) begin
                    occ        <= '0;
                    rd_ptr     <= '0;
                    block_done <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 3'd1;
                end
            end
        end
    end

    scr_buf #(.DATA_W(DATA_W)) u_buf (
        .clk   (clk),
        .we    (wr),
        .waddr (in_index),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_descrambler.sv
// Directed-vector bench for the descrambler with hand-computed expected data.
module tb_descrambler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_index;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       block_done;
    logic       err_dup;
    logic       err_range;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_d [8];

    descrambler #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_index   (in_index),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .block_done (block_done),
        .err_dup    (err_dup),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] idx, input logic [7:0] d);
        in_valid = 1'b1;
        in_index = idx;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   in_ready,   1'b1);
        chk({tag, "_out_valid"},  out_valid,  1'b0);
        chk({tag, "_out_data"},   out_data,   8'h00);
        chk({tag, "_block_done"}, block_done, 1'b0);
        chk({tag, "_err_dup"},    err_dup,    1'b0);
        chk({tag, "_err_range"},  err_range,  1'b0);
    endtask

    // Drains n symbols, applying out_ready from pat one bit per cycle (LSB first).
    task automatic drain(input int n, input logic [15:0] pat);
        int ptr = 0;
        int cyc = 0;
        while (ptr < n && cyc < 16) begin
            out_ready = pat[cyc];
            chk("drain_out_valid", out_valid, 1'b1);
            chk("drain_out_data", out_data, exp_d[ptr]);
            chk("drain_in_ready", in_ready, 1'b0);
            chk("drain_err_dup", err_dup, 1'b0);
            step();
            if (pat[cyc]) ptr++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("drain_count", ptr, n);
        chk("block_done_pulse", block_done, 1'b1);
        chk("post_out_valid", out_valid, 1'b0);
        chk("post_in_ready", in_ready, 1'b1);
        step();
        chk("block_done_clear", block_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; in_data = '0;
        in_index = '0; out_ready = 1'b0;
        #3;
        chk_reset_vals("rst");
        step(); step();
        rst = 1'b0;
        step();
        chk_reset_vals("idle");

        // N=4, scrambled order 3,1,0,2
        mode = 2'b00;
        send(3'd3, 8'hA3); send(3'd1, 8'hA1); send(3'd0, 8'hA0);
        chk("t1_not_full", out_valid, 1'b0);
        send(3'd2, 8'hA2);
        chk("t1_latency", out_valid, 1'b1);
        for (int i = 0; i < 4; i++) exp_d[i] = 8'hA0 + 8'(i);
        drain(4, 16'hFFFF);

        // N=6 latched; mode change mid-block must not matter
        mode = 2'b01;
        for (int i = 5; i >= 0; i--) begin
            send(3'(i), 8'h50 + 8'(5 - i));
            mode = 2'b10;
            if (i == 1) chk("t2_not_full", out_valid, 1'b0);
        end
        chk("t2_n6_full", out_valid, 1'b1);
        for (int i = 0; i < 6; i++) exp_d[i] = 8'h55 - 8'(i);
        drain(6, 16'hFFFF);

        // N=8 with a duplicate index 2
        mode = 2'b10;
        send(3'd0, 8'h80); send(3'd1, 8'h81); send(3'd2, 8'h11);
        chk("t3_no_dup_yet", err_dup, 1'b0);
        send(3'd2, 8'h22);
        chk("t3_err_dup", err_dup, 1'b1);
        for (int i = 3; i < 7; i++) begin
            send(3'(i), 8'h80 + 8'(i));
            if (i == 3) chk("t3_err_dup_clear", err_dup, 1'b0);
        end
        chk("t3_waiting_idx7", out_valid, 1'b0);
        send(3'd7, 8'h87);
        chk("t3_full", out_valid, 1'b1);
        for (int i = 0; i < 8; i++) exp_d[i] = 8'h80 + 8'(i);
        exp_d[2] = 8'h11;
        drain(8, 16'hFFFF);

        // Range errors in IDLE use the mode being latched
        mode = 2'b00;
        send(3'd5, 8'hEE);
        chk("t4_err_range_n4", err_range, 1'b1);
        chk("t4_in_ready", in_ready, 1'b1);
        chk("t4_out_valid", out_valid, 1'b0);
        step();
        chk("t4_err_range_clear", err_range, 1'b0);
        mode = 2'b01;
        send(3'd6, 8'hEE);
        chk("t4_err_range_n6", err_range, 1'b1);
        send(3'd5, 8'hEE);
        chk("t4_in_range_n6", err_range, 1'b0);
        chk("t4_no_dup", err_dup, 1'b0);
        // index 5 is now filled at N=6; complete that block
        for (int i = 0; i < 5; i++) send(3'(i), 8'h60 + 8'(i));
        chk("t4_full", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) exp_d[i] = 8'h60 + 8'(i);
        exp_d[5] = 8'hEE;
        drain(6, 16'hFFFF);

        // Stalled drain with in_valid held high
        mode = 2'b00;
        for (int i = 0; i < 4; i++) send(3'(i), 8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_d[i] = 8'hC0 + 8'(i);
        in_valid = 1'b1; in_index = 3'd0; in_data = 8'hEE;
        drain(4, 16'b0000_0000_0011_1001);

        // Reset mid-fill, then a clean N=8 block
        mode = 2'b10;
        send(3'd1, 8'h01); send(3'd4, 8'h04); send(3'd6, 8'h06);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        step();
        rst = 1'b0;
        step();
        chk_reset_vals("abort_idle");
        begin
            logic [2:0] ord [8];
            ord = '{3'd7, 3'd0, 3'd6, 3'd1, 3'd5, 3'd2, 3'd4, 3'd3};
            for (int i = 0; i < 8; i++) begin
                send(ord[i], 8'h70 + 8'(ord[i]));
                chk("t6_no_block_done", block_done, 1'b0);
                chk("t6_no_dup", err_dup, 1'b0);
            end
        end
        chk("t6_full", out_valid, 1'b1);
        for (int i = 0; i < 8; i++) exp_d[i] = 8'h70 + 8'(i);
        drain(8, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/descrambler.md
DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, symbol width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port mode, input, 2, block-length select: 00 -> N=4, 01 -> N=6, 10 -> N=8, 11 -> N=8.
REQ-005 SHALL have port in_valid, input, 1, a scrambled symbol is present.
REQ-006 SHALL have port in_data, input, DATA_W, scrambled symbol.
REQ-007 SHALL have port in_index, input, 3, original position of the symbol, as produced by the scrambler's index generator.
REQ-008 SHALL have port in_ready, output, 1, the block can accept a symbol this cycle.
REQ-009 SHALL have port out_valid, output, 1, a descrambled symbol is present.
REQ-010 SHALL have port out_data, output, DATA_W, descrambled symbol in original order.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the symbol.
REQ-012 SHALL have port block_done, output, 1, one-cycle pulse after the last symbol of a block is accepted downstream.
REQ-013 SHALL have port err_dup, output, 1, one-cycle pulse when an index already filled in the current block is received.
REQ-014 SHALL have port err_range, output, 1, one-cycle pulse when in_index >= N.

Function
REQ-015 SHALL implement the FSM states IDLE, FILL and DRAIN.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 In IDLE and FILL, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-018 On the first input transfer in IDLE, the block SHALL latch mode into an internal N; mode changes SHALL be ignored until the next IDLE.
REQ-019 Each valid transfer SHALL write in_data to buffer[in_index] and set occupancy bit in_index; the FSM SHALL move IDLE -> FILL after that first write.
REQ-020 A transfer to a position whose occupancy bit is already set SHALL be dropped, SHALL leave the buffer unchanged, and SHALL pulse err_dup the next cycle.
REQ-021 A transfer with in_index >= N SHALL be dropped and SHALL pulse err_range the next cycle; this check SHALL apply in IDLE too, using the value being latched.
REQ-022 When all N occupancy bits are set, the FSM SHALL enter DRAIN on the next edge, and out_valid SHALL be 1 from that cycle.
REQ-023 Minimum latency SHALL be 1 cycle from the final write edge to out_valid=1.
REQ-024 In DRAIN, out_data SHALL equal buffer[rd_ptr]; rd_ptr SHALL start at 0 and increment by 1 per output transfer.
REQ-025 out_valid and out_data SHALL hold stable while out_ready=0.
REQ-026 The output transfer at rd_ptr = N-1 SHALL clear occupancy and rd_ptr, return the FSM to IDLE, and pulse block_done for exactly one cycle.
REQ-027 in_ready SHALL be 1 in the cycle after that final output transfer; there SHALL be no same-cycle refill.
REQ-028 Outside DRAIN, out_valid SHALL be 0.

Reset
REQ-029 While rst=1, regardless of clk, the FSM SHALL be IDLE, occupancy=0, rd_ptr=0, N=4, in_ready=1, out_valid=0, out_data=0, block_done=0, err_dup=0 and err_range=0.
REQ-030 Buffer contents SHALL not require reset.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the block with no block_done pulse.

Structure
REQ-032 A shared scrambler package SHALL hold the mode encodings, the mode-to-N mapping function, and the FSM state typedef, shared with the scrambler-side index generator.
REQ-033 The 8 x DATA_W register file with synchronous write and combinational read SHALL be a sub-module named scr_buf; the FSM, occupancy and pointers SHALL stay in descrambler.

Verification
REQ-034 Mode=00; indices 3,1,0,2 with data A3,A1,A0,A2; out_ready=1 -> out_data A0,A1,A2,A3 on consecutive cycles, out_valid 1 cycle after the 4th write, then one block_done pulse.
REQ-035 Mode=01; indices 5,4,3,2,1,0 with data 50..55 -> output 55,54,53,52,51,50; mode switched to 10 mid-block has no effect (N stays 6).
REQ-036 Mode=10; a block with index 2 sent twice (data 11 then 22) -> err_dup pulses once, position 2 outputs 11, and the block completes only after the missing index arrives.
REQ-037 Mode=00; index 5 -> err_range pulse, no write, FSM stays IDLE; mode=01 with index 6 -> err_range pulse.
REQ-038 DRAIN with out_ready toggling 1,0,0,1 -> out_data holds during stalls, no symbol is lost or duplicated, and in_valid=1 during DRAIN is ignored (in_ready=0).
REQ-039 rst pulsed after 3 of 8 FILL writes -> all outputs at reset values; the next full block of 8 descrambles correctly with no block_done from the aborted block.
